matrix_rd_stream: RTL and testbench

MATRIX_RD_STREAM -- requirements
Module: matrix_rd_stream

---
 rtl/matrix_pkg.sv | 4 +
 rtl/matrix_idx_cnt.sv | 26 ++
 rtl/sync_fifo.sv | 40 ++++
 rtl/matrix_rd_stream.sv | 81 ++++++++
 tb/tb_matrix_rd_stream.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the matrix read streamer.
package matrix_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/matrix_idx_cnt.sv
// matrix_idx_cnt: row-major 2D index walker; column wraps into the next row.
module matrix_idx_cnt #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_adv,
   input  logic [W-1:0] i_row_max,
   input  logic [W-1:0] i_col_max,
   output logic         o_eol,
   output logic         o_row_last
);
   logic [W-1:0] r_row, r_col;
   assign o_eol      = r_col == i_col_max;
   assign o_row_last = r_row == i_row_max;
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_adv) begin
         r_col <= o_eol ? '0 : r_col + 1'b1;
         if (o_eol) r_row <= o_row_last ? '0 : r_row + 1'b1;
      end
   end
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with a registered head element and occupancy count.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic [WIDTH-1:0]        i_wdata,
   output logic [WIDTH-1:0]        o_rdata,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic                    o_full,
   output logic                    o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [AW:0]      r_count;
   logic             w_push, w_pop;
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_count = r_count;
   assign o_full  = r_count == (AW+1)'(DEPTH);
   assign o_empty = r_count == '0;
   assign o_rdata = r_mem[r_rptr];
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
   always_ff @(posedge i_clk)
      if (w_push) r_mem[r_wptr] <= i_wdata;
endmodule

// File: rtl/matrix_rd_stream.sv
// matrix_rd_stream: streams a row-major matrix from a 1-cycle-latency read port
// to a valid/ready sink through a small element buffer.
module matrix_rd_stream
   import matrix_pkg::*;
#(
   parameter int DATA_MSB         = 31,
   parameter int MAT_IDX_SIZE_MSB = 3,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      start,
   input  logic [MAT_IDX_SIZE_MSB:0] row_idx_size,
   input  logic [MAT_IDX_SIZE_MSB:0] col_idx_size,
   output logic                      busy,
   output logic                      done,
   output logic                      mat_re,
   input  logic                      mat_rvalid,
   input  logic [DATA_MSB:0]         mat_rdata,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DATA_MSB:0]         m_data,
   output logic                      m_eol,
   output logic                      m_last
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t                    r_state, w_next;
   logic [MAT_IDX_SIZE_MSB:0] r_rsz, r_csz;
   logic                      r_inflight, r_done;
   logic                      w_start, w_pop, w_empty, w_full;
   logic                      w_iss_eol, w_iss_row_last, w_out_eol, w_out_row_last;
   logic [CW-1:0]             w_count;
   assign w_start = start & (r_state == IDLE);
   assign w_pop   = m_valid & m_ready;
   assign m_valid = ~w_empty;
   assign m_eol   = m_valid & w_out_eol;
   assign m_last  = m_eol & w_out_row_last;
   assign done    = r_done;
   always_ff @(posedge CLK)
      r_state <= RST ? IDLE : w_next;
   always_comb
      w_next = (r_state == IDLE && start) ? RUN :
               (r_state == RUN && mat_re && w_iss_eol && w_iss_row_last) ? DRAIN :
               (r_state == DRAIN && w_pop && m_last) ? IDLE : r_state;
   // Counting the in-flight read keeps issue from overrunning the buffer.
   always_comb begin
      mat_re = (r_state == RUN) & ~w_full & ((int'(w_count) + int'(r_inflight)) < FIFO_DEPTH);
      busy   = r_state != IDLE;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rsz      <= '0;
         r_csz      <= '0;
         r_inflight <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         if (w_start) begin
            r_rsz <= row_idx_size;
            r_csz <= col_idx_size;
         end
         r_inflight <= mat_re;
         r_done     <= w_pop & m_last;
      end
   end
   matrix_idx_cnt #(.W(MAT_IDX_SIZE_MSB+1)) u_iss (
      .i_clk(CLK), .i_rst(RST), .i_clr(w_start), .i_adv(mat_re),
      .i_row_max(r_rsz), .i_col_max(r_csz),
      .o_eol(w_iss_eol), .o_row_last(w_iss_row_last)
   );
   matrix_idx_cnt #(.W(MAT_IDX_SIZE_MSB+1)) u_out (
      .i_clk(CLK), .i_rst(RST), .i_clr(w_start), .i_adv(w_pop),
      .i_row_max(r_rsz), .i_col_max(r_csz),
      .o_eol(w_out_eol), .o_row_last(w_out_row_last)
   );
   // Returns without a matching request are dropped here.
   sync_fifo #(.WIDTH(DATA_MSB+1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk(CLK), .i_rst(RST), .i_push(mat_rvalid & r_inflight), .i_pop(w_pop),
      .i_wdata(mat_rdata), .o_rdata(m_data), .o_count(w_count),
      .o_full(w_full), .o_empty(w_empty)
   );
endmodule

// File: tb/tb_matrix_rd_stream.sv
// tb_matrix_rd_stream: randomized scenarios against a row-major beat model
// and a 1-cycle-latency matrix port responder.
module tb_matrix_rd_stream;
   localparam int DEPTH = 4;
   logic        CLK = 0, RST = 1, start = 0, mat_rvalid = 0, m_ready = 0;
   logic [3:0]  row_idx_size = 0, col_idx_size = 0;
   logic [31:0] mat_rdata = 0;
   logic        busy, done, mat_re, m_valid, m_eol, m_last;
   logic [31:0] m_data;
   int          checks = 0, errors = 0, cyc = 0, rd_ptr = 0, re_total = 0;
   logic [31:0] mem [256];
   logic [31:0] q_data[$];
   logic        q_eol[$], q_last[$];
   int          first_re, first_val, last_hs, done_cyc, n_done, max_out;
   logic        busy_at_done;

   always #5 CLK = ~CLK;

   matrix_rd_stream dut (
      .CLK(CLK), .RST(RST), .start(start),
      .row_idx_size(row_idx_size), .col_idx_size(col_idx_size),
      .busy(busy), .done(done), .mat_re(mat_re),
      .mat_rvalid(mat_rvalid), .mat_rdata(mat_rdata),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_eol(m_eol), .m_last(m_last)
   );

   // One clock; the port answers each request with the next element one cycle later.
   task automatic tick();
      bit p;
      p = mat_re;
      @(posedge CLK);
      #1;
      cyc++;
      re_total += int'(p);
      mat_rvalid = p;
      mat_rdata = p ? mem[rd_ptr % 256] : 32'hDEAD_BEEF;
      if (p) rd_ptr++;
   endtask

   task automatic start_mat(input int r, input int c, input bit idx_data);
      for (int k = 0; k < (r+1)*(c+1); k++) mem[k] = idx_data ? 32'(k) : $urandom;
      rd_ptr = 0;
      row_idx_size = 4'(r);
      col_idx_size = 4'(c);
      start = 1;
      tick();
      start = 0;
      re_total = 0;
   endtask

   task automatic collect(input int pct, input int budget, input int restart_at, input int stop_beats);
      q_data.delete(); q_eol.delete(); q_last.delete();
      first_re = -1; first_val = -1; last_hs = -1; done_cyc = -1; n_done = 0; max_out = 0;
      busy_at_done = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
         m_ready = ($urandom_range(99) < pct);
         start = (c == restart_at);
         if (re_total - q_data.size() > max_out) max_out = re_total - q_data.size();
         if (mat_re && first_re < 0) first_re = cyc;
         if (m_valid && first_val < 0) first_val = cyc;
         if (done) begin n_done++; done_cyc = cyc; busy_at_done = busy; end
         if (m_valid && m_ready) begin
            q_data.push_back(m_data); q_eol.push_back(m_eol); q_last.push_back(m_last);
            if (m_last) last_hs = cyc;
         end
         if (stop_beats > 0 && q_data.size() == stop_beats) break;
         tick();
      end
      start = 0;
   endtask

   task automatic test_reset();
      RST = 1; start = 1;
      repeat (3) tick();
      checks++;
      if ({busy, done, mat_re, m_valid, m_eol, m_last} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs: busy/done/re/valid/eol/last=%b, expected 000000", {busy, done, mat_re, m_valid, m_eol, m_last});
      end
      RST = 0; start = 0;
      repeat (2) tick();
      checks++;
      if ({busy, mat_re} !== 2'b0) begin
         errors++;
         $display("FAIL reset_start_ignored: busy/re=%b, expected 00", {busy, mat_re});
      end
   endtask

   task automatic test_basic();
      int n;
      n = 6;
      start_mat(1, 2, 1);
      collect(100, 60, -1, 0);
      checks++;
      if (q_data.size() != n) begin errors++; $display("FAIL basic_count: got %0d beats, expected %0d", q_data.size(), n); end
      foreach (q_data[k]) begin
         checks++;
         if (q_data[k] !== mem[k] || q_eol[k] !== ((k % 3) == 2) || q_last[k] !== (k == n-1)) begin
            errors++;
            $display("FAIL basic_beat%0d: data=%h eol=%b last=%b, expected data=%h eol=%b last=%b", k, q_data[k], q_eol[k], q_last[k], mem[k], (k % 3) == 2, k == n-1);
         end
      end
      checks++;
      if (first_val - first_re != 2) begin errors++; $display("FAIL basic_latency: got %0d cycles, expected 2", first_val - first_re); end
      checks++;
      if (n_done != 1 || done_cyc != last_hs + 1 || busy_at_done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: dones=%0d at %0d busy=%b, expected 1 at %0d busy=0", n_done, done_cyc, busy_at_done, last_hs + 1);
      end
   endtask

   task automatic test_stall();
      int n;
      n = 6;
      start_mat(1, 2, 1);
      collect(0, 12, -1, 0);
      checks++;
      if (re_total != 4 || mat_re !== 1'b0) begin errors++; $display("FAIL stall_reads: got %0d reads re=%b, expected 4 re=0", re_total, mat_re); end
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'd0) begin errors++; $display("FAIL stall_hold: valid=%b data=%h, expected valid=1 data=0", m_valid, m_data); end
      checks++;
      if (max_out > DEPTH) begin errors++; $display("FAIL stall_depth: %0d outstanding, expected <= %0d", max_out, DEPTH); end
      collect(100, 60, -1, 0);
      checks++;
      if (q_data.size() != n || re_total != n) begin
         errors++;
         $display("FAIL stall_count: got %0d beats %0d reads, expected %0d each", q_data.size(), re_total, n);
      end
      foreach (q_data[k]) begin
         checks++;
         if (q_data[k] !== mem[k] || q_eol[k] !== ((k % 3) == 2) || q_last[k] !== (k == n-1)) begin
            errors++;
            $display("FAIL stall_beat%0d: data=%h eol=%b last=%b, expected data=%h eol=%b last=%b", k, q_data[k], q_eol[k], q_last[k], mem[k], (k % 3) == 2, k == n-1);
         end
      end
      checks++;
      if (n_done != 1) begin errors++; $display("FAIL stall_done: got %0d dones, expected 1", n_done); end
   endtask

   task automatic test_one();
      start_mat(0, 0, 0);
      collect(100, 30, -1, 0);
      checks++;
      if (re_total != 1 || q_data.size() != 1) begin
         errors++;
         $display("FAIL one_count: got %0d reads %0d beats, expected 1 and 1", re_total, q_data.size());
      end else begin
         checks++;
         if (q_data[0] !== mem[0] || q_eol[0] !== 1'b1 || q_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL one_beat: data=%h eol=%b last=%b, expected data=%h eol=1 last=1", q_data[0], q_eol[0], q_last[0], mem[0]);
         end
      end
      checks++;
      if (first_val - first_re != 2 || n_done != 1 || done_cyc != last_hs + 1) begin
         errors++;
         $display("FAIL one_timing: latency=%0d dones=%0d done_at=%0d, expected 2, 1, %0d", first_val - first_re, n_done, done_cyc, last_hs + 1);
      end
   endtask

   task automatic test_restart();
      int n;
      n = 16;
      start_mat(3, 3, 0);
      row_idx_size = 0; col_idx_size = 0;
      collect(100, 120, 3, 0);
      checks++;
      if (q_data.size() != n || n_done != 1) begin
         errors++;
         $display("FAIL restart_count: got %0d beats %0d dones, expected %0d and 1", q_data.size(), n_done, n);
      end
      foreach (q_data[k]) begin
         checks++;
         if (q_data[k] !== mem[k] || q_eol[k] !== ((k % 4) == 3) || q_last[k] !== (k == n-1)) begin
            errors++;
            $display("FAIL restart_beat%0d: data=%h eol=%b last=%b, expected data=%h eol=%b last=%b", k, q_data[k], q_eol[k], q_last[k], mem[k], (k % 4) == 3, k == n-1);
         end
      end
   endtask

   task automatic test_reset_mid();
      int dn;
      dn = 0;
      start_mat(3, 3, 0);
      collect(100, 120, -1, 5);
      RST = 1;
      tick();
      checks++;
      if ({busy, m_valid, done, mat_re} !== 4'b0) begin
         errors++;
         $display("FAIL abort_outputs: busy/valid/done/re=%b, expected 0000", {busy, m_valid, done, mat_re});
      end
      RST = 0;
      repeat (4) begin tick(); dn += int'(done | m_valid); end
      checks++;
      if (dn != 0) begin errors++; $display("FAIL abort_quiet: %0d cycles with done or valid, expected 0", dn); end
      start_mat(1, 1, 0);
      collect(100, 60, -1, 0);
      checks++;
      if (q_data.size() != 4 || n_done != 1) begin
         errors++;
         $display("FAIL abort_restart_count: got %0d beats %0d dones, expected 4 and 1", q_data.size(), n_done);
      end
      foreach (q_data[k]) begin
         checks++;
         if (q_data[k] !== mem[k] || q_eol[k] !== ((k % 2) == 1) || q_last[k] !== (k == 3)) begin
            errors++;
            $display("FAIL abort_beat%0d: data=%h eol=%b last=%b, expected data=%h eol=%b last=%b", k, q_data[k], q_eol[k], q_last[k], mem[k], (k % 2) == 1, k == 3);
         end
      end
   endtask

   task automatic test_random();
      int n, eols, lasts, bad;
      n = 256; eols = 0; lasts = 0; bad = -1;
      start_mat(15, 15, 0);
      collect(50, 3000, -1, 0);
      foreach (q_data[k]) begin
         eols += int'(q_eol[k]);
         lasts += int'(q_last[k]);
         if (bad < 0 && (q_data[k] !== mem[k] || q_eol[k] !== ((k % 16) == 15) || q_last[k] !== (k == n-1))) bad = k;
      end
      checks++;
      if (q_data.size() != n || bad >= 0) begin
         errors++;
         $display("FAIL random_stream: got %0d beats first bad %0d, expected %0d in order", q_data.size(), bad, n);
      end
      checks++;
      if (eols != 16 || lasts != 1 || n_done != 1) begin
         errors++;
         $display("FAIL random_flags: eol=%0d last=%0d done=%0d, expected 16 1 1", eols, lasts, n_done);
      end
      checks++;
      if (max_out > DEPTH) begin errors++; $display("FAIL random_depth: %0d outstanding, expected <= %0d", max_out, DEPTH); end
   endtask

   task automatic test_back_to_back();
      int r, c, n;
      for (int it = 0; it < 4; it++) begin
         r = $urandom_range(3); c = $urandom_range(3); n = (r+1)*(c+1);
         start_mat(r, c, 0);
         collect($urandom_range(100, 30), 300, -1, 0);
         checks++;
         if (q_data.size() != n || n_done != 1) begin
            errors++;
            $display("FAIL b2b%0d_count: got %0d beats %0d dones, expected %0d and 1", it, q_data.size(), n_done, n);
         end
         foreach (q_data[k]) begin
            checks++;
            if (q_data[k] !== mem[k] || q_eol[k] !== ((k % (c+1)) == c) || q_last[k] !== (k == n-1)) begin
               errors++;
               $display("FAIL b2b%0d_beat%0d: data=%h eol=%b last=%b, expected data=%h eol=%b last=%b", it, k, q_data[k], q_eol[k], q_last[k], mem[k], (k % (c+1)) == c, k == n-1);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_one();
      test_restart();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
